// File: rtl/fetch_unit_pkg.sv
// Shared widths and fetch defaults for the fetch stage and its neighbours.
// context_manager sizes its request window from FETCH_DEPTH / FETCH_IMEM_LAT.
package fetch_unit_pkg;

  localparam int unsigned LEN_WORD       = 32;
  localparam int unsigned LEN_INST       = 32;
  localparam int unsigned LEN_CONTEXT    = 4;

  localparam int unsigned FETCH_DEPTH    = 4;
  localparam int unsigned FETCH_IMEM_LAT = 2;

  typedef struct packed {
    logic [LEN_INST-1:0]    instr;
    logic [LEN_WORD-1:0]    pc;
    logic [LEN_CONTEXT-1:0] ctx;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: synchronous write, combinational head read,
// synchronous clear of pointers and occupancy.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         wr_en,
  input  fetch_entry_t                 wr_data,
  input  logic                         rd_en,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

  a_count_bound: assert property (@(posedge clk) disable iff (clear) count <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (clear) !(wr_en && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (clear) !(rd_en && count == '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues BRAM reads for accepted requests, tracks them through a
// fixed-latency shift register and buffers returned words for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_LAT = FETCH_IMEM_LAT,
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [LEN_WORD-1:0]    req_pc,
  input  logic [LEN_CONTEXT-1:0] req_context,
  output logic                   req_ready,
  input  logic                   flush,
  output logic                   imem_en,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [LEN_INST-1:0]    imem_rdata,
  output logic                   order,
  output logic [LEN_INST-1:0]    instr,
  output logic [LEN_WORD-1:0]    pc,
  output logic [LEN_CONTEXT-1:0] context_in,
  input  logic                   dec_ready
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned FW = $clog2(DEPTH+IMEM_LAT+1);

  logic [IMEM_LAT-1:0]    vld;
  logic [LEN_WORD-1:0]    sr_pc  [IMEM_LAT];
  logic [LEN_CONTEXT-1:0] sr_ctx [IMEM_LAT];

  logic                   acc;
  logic                   clear;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          count;
  logic [FW-1:0]          inflight;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;

  assign clear = rst | flush;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < IMEM_LAT; i++) begin
      inflight = inflight + FW'(vld[i]);
    end
  end

  // Credit check uses registered occupancy only; a same-cycle pop is not counted.
  assign req_ready = ~clear & ((FW'(count) + inflight) < FW'(DEPTH));
  assign acc       = req_valid & req_ready;
  assign imem_en   = acc;
  assign imem_addr = req_pc[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (clear) begin
      vld <= '0;
    end else begin
      vld[0] <= acc;
      for (int unsigned i = 1; i < IMEM_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_pc[0]  <= req_pc;
    sr_ctx[0] <= req_context;
    for (int unsigned i = 1; i < IMEM_LAT; i++) begin
      sr_pc[i]  <= sr_pc[i-1];
      sr_ctx[i] <= sr_ctx[i-1];
    end
  end

  // A word landing on a flush/reset edge belongs to a killed fetch and is dropped.
  assign push = vld[IMEM_LAT-1] & ~clear;

  always_comb begin
    wr_entry       = '0;
    wr_entry.instr = imem_rdata;
    wr_entry.pc    = sr_pc[IMEM_LAT-1];
    wr_entry.ctx   = sr_ctx[IMEM_LAT-1];
  end

  assign order = (count != '0) & ~clear;
  assign pop   = order & dec_ready;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clear   (clear),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign instr      = head.instr;
  assign pc         = head.pc;
  assign context_in = head.ctx;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an exact-latency BRAM model and an
// acceptance-order scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 14;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid;
  logic [LEN_WORD-1:0]    req_pc;
  logic [LEN_CONTEXT-1:0] req_context;
  logic                   req_ready;
  logic                   flush;
  logic                   imem_en;
  logic [ADDR_W-1:0]      imem_addr;
  logic [LEN_INST-1:0]    imem_rdata;
  logic                   order;
  logic [LEN_INST-1:0]    instr;
  logic [LEN_WORD-1:0]    pc;
  logic [LEN_CONTEXT-1:0] context_in;
  logic                   dec_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .IMEM_LAT (LAT),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_context (req_context),
    .req_ready   (req_ready),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .order       (order),
    .instr       (instr),
    .pc          (pc),
    .context_in  (context_in),
    .dec_ready   (dec_ready)
  );

  function automatic logic [LEN_INST-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + LEN_INST'(a);
  endfunction

  logic [LEN_INST-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign imem_rdata = rd_pipe[LAT-1];

  fetch_entry_t        exp_q[$];
  int                  total = 0;
  int                  bad   = 0;
  int                  cyc   = 0;
  int                  n_acc, n_pop, first_acc, last_acc_cyc, first_pop, last_pop;
  bit                  last_acc;
  logic [LEN_INST-1:0] last_instr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    n_acc = 0; n_pop = 0;
    first_acc = -1; last_acc_cyc = -1; first_pop = -1; last_pop = -1;
  endtask

  // One clock: sample at negedge, update scoreboard, return #1 after posedge.
  task automatic cycle(input bit quiet);
    fetch_entry_t e;
    @(negedge clk);
    cyc++;
    if (quiet) begin
      check("quiet_order", 64'(order), 64'd0);
      if (rst || flush) begin
        check("quiet_req_ready", 64'(req_ready), 64'd0);
        check("quiet_imem_en", 64'(imem_en), 64'd0);
      end
    end
    if (rst || flush) exp_q.delete();
    last_acc = req_valid && (req_ready === 1'b1);
    if (last_acc) begin
      check("imem_en", 64'(imem_en), 64'd1);
      check("imem_addr", 64'(imem_addr), 64'(req_pc[ADDR_W+1:2]));
      e.instr = mem_word(req_pc[ADDR_W+1:2]);
      e.pc    = req_pc;
      e.ctx   = req_context;
      exp_q.push_back(e);
      if (first_acc < 0) first_acc = cyc;
      last_acc_cyc = cyc;
      n_acc++;
    end
    if (order === 1'b1 && dec_ready) begin
      check("pop_has_expect", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr", 64'(instr), 64'(e.instr));
        check("pc", 64'(pc), 64'(e.pc));
        check("context_in", 64'(context_in), 64'(e.ctx));
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop   = cyc;
      last_instr = instr;
      n_pop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LEN_WORD-1:0] p, input logic [LEN_CONTEXT-1:0] c);
    req_valid   = 1'b1;
    req_pc      = p;
    req_context = c;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0);
      if (last_acc) break;
    end
    check("send_accepted", 64'(last_acc), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    dec_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cycle(1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) cycle(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_pc = '0; req_context = '0;
    flush = 1'b0; dec_ready = 1'b0;
    mark();

    // Reset held with a pending request
    repeat (3) cycle(1'b1);
    rst = 1'b0; req_valid = 1'b0;
    cycle(1'b1);

    // Streaming
    mark(); dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(i * 4), 4'(i));
    drain();
    check("stream_acc_span", 64'(last_acc_cyc - first_acc), 64'd15);
    check("stream_latency", 64'(first_pop - first_acc), 64'(LAT + 1));
    check("stream_pop_span", 64'(last_pop - first_pop), 64'd15);
    check("stream_pops", 64'(n_pop), 64'd16);

    // Backpressure
    mark(); dec_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_pc = 32'h100 + 32'(n_acc * 4); req_context = 4'(n_acc);
      cycle(1'b0);
    end
    check("bp_accepts", 64'(n_acc), 64'(DEPTH));
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_order_high", 64'(order), 64'd1);
    drain();
    check("bp_pops", 64'(n_pop), 64'(DEPTH));
    check("bp_ready_back", 64'(req_ready), 64'd1);

    // Flush while two fetches are in flight
    mark(); dec_ready = 1'b1;
    send(32'h40, 4'h1);
    send(32'h44, 4'h2);
    flush = 1'b1;
    cycle(1'b1);
    flush = 1'b0;
    repeat (LAT + 2) cycle(1'b1);
    check("flush_no_pop", 64'(n_pop), 64'd0);
    send(32'h80, 4'h3);
    drain();
    check("flush_pops", 64'(n_pop), 64'd1);
    check("flush_next_instr", 64'(last_instr), 64'h1000_0020);

    // Toggling dec_ready with continuous requests
    mark(); req_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      dec_ready = i[0];
      req_pc = 32'h300 + 32'(n_acc * 4); req_context = 4'(n_acc);
      cycle(1'b0);
    end
    drain();
    check("toggle_pops_min", 64'(n_pop >= 3 * DEPTH), 64'd1);
    check("toggle_all_out", 64'(n_pop), 64'(n_acc));

    // Reset with buffered and in-flight fetches
    mark(); dec_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      req_pc = 32'h400 + 32'(n_acc * 4); req_context = 4'(n_acc);
      cycle(1'b0);
    end
    check("rst_fill", 64'(n_acc), 64'(DEPTH));
    req_valid = 1'b0; rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0; dec_ready = 1'b1;
    repeat (LAT + 3) cycle(1'b1);
    check("rst_no_pop", 64'(n_pop), 64'd0);
    send(32'h200, 4'h5);
    drain();
    check("rst_recover", 64'(last_instr), 64'h1000_0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
